// File: rtl/hash_target_check.sv
// hash_target_check: checks each incoming 256-bit hash against a 64-bit share
// target and queues hits ({nonce, compare value}) in a first-word-fall-through
// share FIFO. It also keeps hash/share/drop statistics.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_valid/o_ready   upstream hash handshake (i_result, i_nonce, i_target)
//   o_valid/i_ready   downstream share handshake (o_nonce, o_hash64)
//   i_clear_stats     single-cycle pulse that zeroes all statistics
//   o_hash_count      hashes checked (wraps)
//   o_share_count     shares found, including dropped shares (wraps)
//   o_drop_count      shares dropped on a full FIFO (saturates)
//   o_overflow        sticky flag, set when any share is dropped
module hash_target_check #(
  parameter int unsigned nonce_width = 7,
  parameter int unsigned fifo_depth  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [255:0]           i_result,
  input  logic [nonce_width-1:0] i_nonce,
  input  logic [63:0]            i_target,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [nonce_width-1:0] o_nonce,
  output logic [63:0]            o_hash64,
  input  logic                   i_clear_stats,
  output logic [31:0]            o_hash_count,
  output logic [31:0]            o_share_count,
  output logic [15:0]            o_drop_count,
  output logic                   o_overflow
);

  localparam int unsigned val_w   = 64;
  localparam int unsigned entry_w = nonce_width + val_w;
  localparam int unsigned ptr_w   = $clog2(fifo_depth);
  localparam int unsigned cnt_w   = ptr_w + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PUSH  = 2'd2
  } state_t;

  state_t                 state;
  logic [val_w-1:0]       value_q;
  logic [val_w-1:0]       target_q;
  logic [nonce_width-1:0] nonce_q;

  logic [entry_w-1:0] mem [fifo_depth];
  logic [ptr_w-1:0]   rd_ptr;
  logic [ptr_w-1:0]   wr_ptr;
  logic [cnt_w-1:0]   count;

  logic               hit_c;
  logic               pop_c;
  logic               has_space_c;
  logic               push_c;
  logic               drop_c;
  logic [entry_w-1:0] wdata_c;
  logic [ptr_w-1:0]   rd_ptr_nxt_c;
  logic [ptr_w-1:0]   wr_ptr_nxt_c;
  logic [cnt_w-1:0]   count_nxt_c;
  logic [entry_w-1:0] head_nxt_c;

  // Strict unsigned compare: target 0 never hits.
  assign hit_c = value_q < target_q;

  // A pop in the PUSH cycle frees a slot, so a full FIFO still accepts then.
  assign pop_c       = o_valid && i_ready;
  assign has_space_c = (count != cnt_w'(fifo_depth)) || pop_c;
  assign push_c      = (state == PUSH) && has_space_c;
  assign drop_c      = (state == PUSH) && !has_space_c;
  assign wdata_c     = {nonce_q, value_q};

  // Control FSM with registered o_ready; captures the compare operands at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      o_ready  <= 1'b1;
      value_q  <= '0;
      target_q <= '0;
      nonce_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            value_q  <= i_result[255:192];
            target_q <= i_target;
            nonce_q  <= i_nonce;
            state    <= CHECK;
            o_ready  <= 1'b0;
          end
        end
        CHECK: begin
          state   <= hit_c ? PUSH : IDLE;
          o_ready <= !hit_c;
        end
        PUSH: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

  // Statistics; clear wins over any increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_hash_count  <= '0;
      o_share_count <= '0;
      o_drop_count  <= '0;
      o_overflow    <= 1'b0;
    end else if (i_clear_stats) begin
      o_hash_count  <= '0;
      o_share_count <= '0;
      o_drop_count  <= '0;
      o_overflow    <= 1'b0;
    end else begin
      if (state == CHECK) begin
        o_hash_count <= o_hash_count + 32'd1;
      end
      if (state == PUSH) begin
        o_share_count <= o_share_count + 32'd1;
      end
      if (drop_c) begin
        o_overflow <= 1'b1;
        if (o_drop_count != 16'hFFFF) begin
          o_drop_count <= o_drop_count + 16'd1;
        end
      end
    end
  end

  // Next FIFO pointers/occupancy and the entry that will sit at the head.
  always_comb begin
    rd_ptr_nxt_c = rd_ptr;
    wr_ptr_nxt_c = wr_ptr;
    count_nxt_c  = count;
    if (pop_c) begin
      rd_ptr_nxt_c = rd_ptr + ptr_w'(1);
    end
    if (push_c) begin
      wr_ptr_nxt_c = wr_ptr + ptr_w'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_nxt_c = count + cnt_w'(1);
      2'b01:   count_nxt_c = count - cnt_w'(1);
      default: count_nxt_c = count;
    endcase
    head_nxt_c = mem[rd_ptr_nxt_c];
    // The entry being written becomes the head when it lands at the next read slot.
    if (push_c && (wr_ptr == rd_ptr_nxt_c)) begin
      head_nxt_c = wdata_c;
    end
    if (count_nxt_c == '0) begin
      head_nxt_c = '0;
    end
  end

  // FIFO pointers and registered first-word-fall-through head outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      o_valid  <= 1'b0;
      o_nonce  <= '0;
      o_hash64 <= '0;
    end else begin
      rd_ptr   <= rd_ptr_nxt_c;
      wr_ptr   <= wr_ptr_nxt_c;
      count    <= count_nxt_c;
      o_valid  <= (count_nxt_c != '0);
      o_nonce  <= head_nxt_c[entry_w-1:val_w];
      o_hash64 <= head_nxt_c[val_w-1:0];
    end
  end

  // Share storage; contents are only observed through the head registers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= wdata_c;
    end
  end

endmodule

// File: doc/hash_target_check.md
HASH_TARGET_CHECK -- requirements
Module: hash_target_check

Interface
REQ-001 Parameter nonce_width, default 7, width of the nonce tag carried with each hash.
REQ-002 Parameter fifo_depth, default 4, number of entries in the share FIFO; must be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_valid  input  1  upstream hash valid (ready/valid protocol).
REQ-006 o_ready  output  1  block can accept a hash.
REQ-007 i_result  input  256  final hash; hash byte k sits on bits [8k+7:8k].
REQ-008 i_nonce  input  nonce_width  nonce tag of the hash.
REQ-009 i_target  input  64  share target; sampled only at accept.
REQ-010 o_valid  output  1  a share is available at the FIFO head.
REQ-011 i_ready  input  1  downstream consumes the share.
REQ-012 o_nonce  output  nonce_width  nonce of the head share.
REQ-013 o_hash64  output  64  compare value of the head share.
REQ-014 i_clear_stats  input  1  single-cycle pulse that zeroes the statistics.
REQ-015 o_hash_count  output  32  hashes checked; wraps on overflow.
REQ-016 o_share_count  output  32  shares found, including dropped shares; wraps on overflow.
REQ-017 o_drop_count  output  16  shares lost to a full FIFO; saturates at 0xFFFF.
REQ-018 o_overflow  output  1  sticky; set when any share is dropped.

Function
REQ-019 The compare value SHALL be i_result[255:192] as an unsigned integer (hash bytes 24..31, little-endian, byte 31 most significant).
REQ-020 The FSM SHALL have three states:
- IDLE: o_ready=1.
- CHECK: o_ready=0.
- PUSH: o_ready=0.
REQ-021 In IDLE, on i_valid&&o_ready, the block SHALL register the compare value, i_nonce and i_target, and go to CHECK.
REQ-022 In CHECK, the block SHALL:
- increment o_hash_count;
- evaluate hit = value < target (strict, unsigned);
- go to PUSH on a hit, otherwise go to IDLE.
REQ-023 Consequences of the strict compare: target 0 never hits; target 0xFFFF_FFFF_FFFF_FFFF hits unless the value is all ones.
REQ-024 In PUSH, the block SHALL increment o_share_count and go to IDLE.
- If the FIFO has space, or the head is popped in the same cycle, it writes {nonce, value}.
- Otherwise it drops the share, increments o_drop_count (saturating) and sets o_overflow.
REQ-025 Latency is measured from accept at cycle 0:
- CHECK occurs at cycle 1.
- On a miss, o_ready is high again at cycle 2.
- On a hit, PUSH occurs at cycle 2, o_valid is high at cycle 3 (empty FIFO), and o_ready is high at cycle 3.
REQ-026 The FIFO SHALL be first-word-fall-through.
- o_valid = not empty; o_nonce and o_hash64 show the head entry.
- A pop occurs on o_valid&&i_ready.
- Pop on empty has no effect.
- Read and write pointers wrap modulo fifo_depth.
- Order is preserved.
REQ-027 Simultaneous push and pop SHALL leave the occupancy unchanged, including when the FIFO is full.
REQ-028 o_nonce and o_hash64 SHALL hold their value while o_valid=1 and i_ready=0.
REQ-029 When i_clear_stats=1, all four statistics SHALL be zero on the next cycle; clear takes precedence over any increment in the same cycle.
REQ-030 i_clear_stats SHALL NOT affect the FSM or the FIFO contents.
REQ-031 i_valid while o_ready=0 SHALL be ignored; upstream holds it.

Reset
REQ-032 Asserting rst at any time, including mid-operation, SHALL immediately force all of the following:
- state=IDLE, o_ready=1 (after release);
- FIFO empty, o_valid=0, o_nonce=0, o_hash64=0;
- all counters 0, o_overflow=0.
REQ-033 A hash in flight at reset SHALL be discarded and not counted.

Verification
REQ-034 Miss: value 0x0000_0001_0000_0000, target 0x0000_0000_FFFF_FFFF -> o_hash_count=1, o_share_count=0, o_valid stays 0, o_ready high 2 cycles after accept.
REQ-035 Hit and boundary: value 0x10, target 0x11 -> o_valid at cycle 3, o_hash64=0x10, nonce matches. Value 0x11, target 0x11 -> miss.
REQ-036 FIFO full: i_ready=0, five hits with nonces 1..5, depth 4 -> FIFO holds 1..4 in order; o_drop_count=1; o_overflow=1; o_share_count=5.
REQ-037 Full with pop in PUSH: FIFO full, i_ready=1 during PUSH -> no drop; head 1 leaves; entry 5 is enqueued last.
REQ-038 Clear collision: i_clear_stats coincident with CHECK -> o_hash_count=0 next cycle. Assert rst during CHECK after a hit -> no share output, all counters 0.
